// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared FSM encoding and field constants for the GF power engine
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } gf_state_e;

  // Multiplicative identity, cast to the field width at the point of use
  localparam int unsigned GF_ONE = 1;
  localparam logic [8:0]  GF_PRIM_DEFAULT = 9'h11B;

endpackage

// File: rtl/gf_mult.sv
// rtl/gf_mult.sv - combinational GF(2^N) multiplier, p = a*b mod prim
module gf_mult #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N:0]   prim_i,
  output logic [N-1:0] p_o
);

  logic [N-1:0] aa;
  logic [N:0]   sh;

  // Shift-and-add: aa walks through a*x^i reduced, accumulated where b has a one
  always_comb begin
    p_o = '0;
    aa  = a_i;
    sh  = '0;
    for (int i = 0; i < N; i++) begin
      if (b_i[i]) p_o = p_o ^ aa;
      sh = {aa, 1'b0};
      if (sh[N]) sh = sh ^ prim_i;
      aa = sh[N-1:0];
    end
  end

endmodule

// File: rtl/gf_pow_ctrl.sv
// rtl/gf_pow_ctrl.sv - sequenced GF(2^N) square-and-multiply power engine (option: GF_POW_INV_EN)
module gf_pow_ctrl
  import gf_pkg::*;
#(
  parameter int N = 8,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_base,
  input  logic [E-1:0] in_exp,
  input  logic [N:0]   in_prim,
`ifdef GF_POW_INV_EN
  input  logic         in_inv,
  output logic         out_err,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam logic [N-1:0] ONE = N'(GF_ONE);

  if (E < N) begin : g_bad_exp_width
    $error("gf_pow_ctrl: E must be >= N");
  end

  gf_state_e    state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0] base_q, base_d;
  logic [E-1:0] exp_q, exp_d;
  logic [N:0]   prim_q, prim_d;
  logic [N-1:0] data_q, data_d;
  logic [N-1:0] mult_b, mult_p;

`ifdef GF_POW_INV_EN
  localparam logic [E-1:0] INV_EXP = E'((2 ** N) - 2);
  logic err_q, err_d;
`endif

  // One shared multiplier: squaring in SQR, multiply-by-base in MUL
  assign mult_b = (state_q == MUL) ? base_q : acc_q;

  gf_mult #(.N(N)) u_mult (
    .a_i    (acc_q),
    .b_i    (mult_b),
    .prim_i (prim_q),
    .p_o    (mult_p)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    base_d  = base_q;
    exp_d   = exp_q;
    prim_d  = prim_q;
    data_d  = data_q;
`ifdef GF_POW_INV_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d  = in_base;
          exp_d   = in_exp;
          prim_d  = in_prim;
          acc_d   = ONE;
          idx_d   = IW'(E - 1);
          state_d = SQR;
`ifdef GF_POW_INV_EN
          err_d = 1'b0;
          if (in_inv) begin
            exp_d = INV_EXP;
            err_d = (in_base == '0);
          end
`endif
        end
      end
      SQR: begin
        acc_d = mult_p;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = DONE;
          data_d  = mult_p;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      MUL: begin
        acc_d = mult_p;
        if (idx_q == '0) begin
          state_d = DONE;
          data_d  = mult_p;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      prim_q  <= '0;
      data_q  <= '0;
`ifdef GF_POW_INV_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      prim_q  <= prim_d;
      data_q  <= data_d;
`ifdef GF_POW_INV_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SQR) || (state_q == MUL);
  assign out_data  = data_q;
`ifdef GF_POW_INV_EN
  assign out_err   = err_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_gf_pow_ctrl.sv
// tb/tb_gf_pow_ctrl.sv - self-checking bench for gf_pow_ctrl against a repeated-multiplication model
module tb_gf_pow_ctrl;
  import gf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_base = '0;
  logic [7:0] in_exp = '0;
  logic [8:0] in_prim = GF_PRIM_DEFAULT;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;
`ifdef GF_POW_INV_EN
  logic       in_inv = 1'b0;
  logic       out_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  gf_pow_ctrl #(.N(8), .E(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .in_prim   (in_prim),
`ifdef GF_POW_INV_EN
    .in_inv    (in_inv),
    .out_err   (out_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full carry-less product, then long division by the polynomial
  function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b, logic [8:0] p);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'(p) << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_pow(logic [7:0] b, logic [7:0] e, logic [8:0] p);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < int'(e); i++) r = ref_mul(r, b, p);
    return r;
  endfunction

  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [8:0] p,
                        input logic inv, input int hold, input string tag,
                        output logic [7:0] got);
    logic [7:0] ee, want;
    int lat, cyc;
    ee   = inv ? 8'hFE : e;
    want = ref_pow(b, ee, p);
    lat  = 8 + $countones(ee);
    cyc = 0;
    while (!in_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    in_base = b; in_exp = e; in_prim = p; in_valid = 1'b1;
`ifdef GF_POW_INV_EN
    in_inv = inv;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " busy_after_accept"}, busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " data"}, out_data, want);
    chk({tag, " in_ready_in_done"}, in_ready, 0);
`ifdef GF_POW_INV_EN
    chk({tag, " err"}, out_err, (inv && b == 8'h00) ? 1 : 0);
`endif
    got = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, {out_valid, in_ready, busy}, 3'b100);
      chk({tag, " hold_data"}, out_data, want);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " after_hs"}, {out_valid, in_ready}, 2'b01);
    chk({tag, " data_kept"}, out_data, want);
  endtask

  initial begin
    logic [7:0] got, rb, re, want;
    logic [8:0] rp;
    int cyc;

    #2;
    chk("reset_state", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h02, 8'h08, 9'h11B, 1'b0, 0, "pow_02_08", got);
    chk("pow_02_08 const", got, 8'h1B);
    run_op(8'h57, 8'h02, 9'h11B, 1'b0, 1, "pow_57_02", got);
    chk("pow_57_02 const", got, 8'hA5);
    run_op(8'h03, 8'h00, 9'h11B, 1'b0, 0, "exp_zero", got);
    chk("exp_zero const", got, 8'h01);
    run_op(8'h00, 8'h00, 9'h11B, 1'b0, 0, "zero_pow_zero", got);
    chk("zero_pow_zero const", got, 8'h01);
    run_op(8'h00, 8'h05, 9'h11B, 1'b0, 0, "zero_base", got);
    chk("zero_base const", got, 8'h00);
    run_op(8'h01, 8'hFF, 9'h11B, 1'b0, 0, "one_base_max_exp", got);
    chk("one_base const", got, 8'h01);
    run_op(8'h57, 8'h02, 9'h11B, 1'b0, 5, "hold5", got);

`ifdef GF_POW_INV_EN
    run_op(8'h53, 8'h00, 9'h11B, 1'b1, 0, "inv_53", got);
    chk("inv_53 const", got, 8'hCA);
    run_op(8'h00, 8'h33, 9'h11B, 1'b1, 0, "inv_00", got);
    chk("inv_00 const", got, 8'h00);
`endif

    // Back-to-back: second operand presented while the first sits in DONE
    in_base = 8'h02; in_exp = 8'h03; in_prim = 9'h11B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_base = 8'h57; in_exp = 8'h81;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b2b first data", out_data, ref_pow(8'h02, 8'h03, 9'h11B));
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      chk("b2b no_accept_in_done", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b idle_after_hs", {out_valid, in_ready, busy}, 3'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b accepted", {in_ready, busy}, 2'b01);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b2b second latency", cyc, 8 + 2);
    chk("b2b second data", out_data, ref_pow(8'h57, 8'h81, 9'h11B));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset during the squaring phase
    in_base = 8'h35; in_exp = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset outputs", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h35, 8'h0B, 9'h11B, 1'b0, 0, "after_reset", got);

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      re = 8'($urandom);
      rp = ($urandom_range(0, 1) == 0) ? 9'h11B : 9'h11D;
      want = ref_pow(rb, re, rp);
      run_op(rb, re, rp, 1'b0, $urandom_range(0, 2), $sformatf("rand%0d", n), got);
      chk($sformatf("rand%0d model", n), got, want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
